// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64 pipeline constants for ALU function codes and register indices
package riscv_pkg;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [4:0] REG_ZERO    = 5'd0;
endpackage

// File: rtl/forward_mux.sv
// forward_mux: picks the freshest value of one source register from EX/MEM, MEM/WB or the held read data
module forward_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [4:0]      i_src_addr,
  input  logic [XLEN-1:0] i_src_data,
  input  logic            i_exmem_reg_write,
  input  logic [4:0]      i_exmem_rd_addr,
  input  logic [XLEN-1:0] i_exmem_rd_data,
  input  logic            i_memwb_reg_write,
  input  logic [4:0]      i_memwb_rd_addr,
  input  logic [XLEN-1:0] i_memwb_rd_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_exmem_hit
);
  logic w_memwb_hit;
  assign o_exmem_hit = i_exmem_reg_write && i_exmem_rd_addr != REG_ZERO && i_exmem_rd_addr == i_src_addr;
  assign w_memwb_hit = i_memwb_reg_write && i_memwb_rd_addr != REG_ZERO && i_memwb_rd_addr == i_src_addr;
  assign o_data = o_exmem_hit ? i_exmem_rd_data : w_memwb_hit ? i_memwb_rd_data : i_src_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with forwarding, load-use stall and ALU function normalisation
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_dec_valid,
  output logic             o_dec_ready,
  input  logic [2:0]       i_dec_funct3,
  input  logic [6:0]       i_dec_funct7,
  input  logic [4:0]       i_dec_rs1_addr,
  input  logic [4:0]       i_dec_rs2_addr,
  input  logic [4:0]       i_dec_rd_addr,
  input  logic [XLEN-1:0]  i_dec_rs1_data,
  input  logic [XLEN-1:0]  i_dec_rs2_data,
  input  logic [XLEN-1:0]  i_dec_imm,
  input  logic             i_dec_alu_src,
  input  logic             i_dec_reg_write,
  input  logic             i_dec_mem_read,
  input  logic             i_dec_mem_write,
  input  logic             i_exmem_reg_write,
  input  logic             i_exmem_mem_read,
  input  logic [4:0]       i_exmem_rd_addr,
  input  logic [XLEN-1:0]  i_exmem_rd_data,
  input  logic             i_memwb_reg_write,
  input  logic [4:0]       i_memwb_rd_addr,
  input  logic [XLEN-1:0]  i_memwb_rd_data,
  output logic             o_ex_valid,
  input  logic             i_ex_ready,
  output logic [2:0]       o_ex_funct3,
  output logic [6:0]       o_ex_funct7,
  output logic [XLEN-1:0]  o_ex_rs1,
  output logic [XLEN-1:0]  o_ex_rs2,
  output logic [XLEN-1:0]  o_ex_store_data,
  output logic [4:0]       o_ex_rd_addr,
  output logic             o_ex_reg_write,
  output logic             o_ex_mem_read,
  output logic             o_ex_mem_write,
  output logic [CNT_W-1:0] o_stall_cycles
);
  logic             r_valid, r_alu_src, r_reg_write, r_mem_read, r_mem_write;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  logic [4:0]       r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [XLEN-1:0]  r_rs1_data, r_rs2_data, r_imm;
  logic [CNT_W-1:0] r_stall;
  logic [XLEN-1:0]  w_rs1_fwd, w_rs2_fwd;
  logic             w_rs1_hit, w_rs2_hit, w_hazard, w_fire, w_load, w_mem;

  forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .i_src_addr(r_rs1_addr), .i_src_data(r_rs1_data),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd_addr(i_exmem_rd_addr), .i_exmem_rd_data(i_exmem_rd_data),
    .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd_addr(i_memwb_rd_addr), .i_memwb_rd_data(i_memwb_rd_data),
    .o_data(w_rs1_fwd), .o_exmem_hit(w_rs1_hit)
  );
  forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .i_src_addr(r_rs2_addr), .i_src_data(r_rs2_data),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd_addr(i_exmem_rd_addr), .i_exmem_rd_data(i_exmem_rd_data),
    .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd_addr(i_memwb_rd_addr), .i_memwb_rd_data(i_memwb_rd_data),
    .o_data(w_rs2_fwd), .o_exmem_hit(w_rs2_hit)
  );

  // rs2 only matters for a load-use stall when it feeds the ALU or the store data
  assign w_hazard    = r_valid && i_exmem_mem_read && (w_rs1_hit || ((!r_alu_src || r_mem_write) && w_rs2_hit));
  assign o_ex_valid  = r_valid && !w_hazard;
  assign w_fire      = o_ex_valid && i_ex_ready;
  assign o_dec_ready = !r_valid || w_fire;
  assign w_load      = i_dec_valid && o_dec_ready && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_stall     <= '0;
    end else begin
      if (w_hazard) r_stall <= r_stall + CNT_W'(1);
      if (i_flush) r_valid <= 1'b0;
      else if (w_load) begin
        r_valid     <= 1'b1;
        r_funct3    <= i_dec_funct3;
        r_funct7    <= i_dec_funct7;
        r_rs1_addr  <= i_dec_rs1_addr;
        r_rs2_addr  <= i_dec_rs2_addr;
        r_rd_addr   <= i_dec_rd_addr;
        r_rs1_data  <= i_dec_rs1_data;
        r_rs2_data  <= i_dec_rs2_data;
        r_imm       <= i_dec_imm;
        r_alu_src   <= i_dec_alu_src;
        r_reg_write <= i_dec_reg_write;
        r_mem_read  <= i_dec_mem_read;
        r_mem_write <= i_dec_mem_write;
      end else if (w_fire) r_valid <= 1'b0;
    end
  end

  // loads/stores compute an address add; shift-immediates carry the arithmetic bit in imm[10]
  assign w_mem           = r_mem_read || r_mem_write;
  assign o_ex_funct3     = w_mem ? FUNCT3_ADD : r_funct3;
  assign o_ex_funct7     = w_mem ? FUNCT7_BASE
                         : r_alu_src ? ((r_funct3 == FUNCT3_SR && r_imm[10]) ? FUNCT7_ALT : FUNCT7_BASE)
                         : r_funct7;
  assign o_ex_rs1        = w_rs1_fwd;
  assign o_ex_rs2        = r_alu_src ? r_imm : w_rs2_fwd;
  assign o_ex_store_data = w_rs2_fwd;
  assign o_ex_rd_addr    = r_rd_addr;
  assign o_ex_reg_write  = r_reg_write && o_ex_valid;
  assign o_ex_mem_read   = r_mem_read && o_ex_valid;
  assign o_ex_mem_write  = r_mem_write && o_ex_valid;
  assign o_stall_cycles  = r_stall;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the pipelined RV64 core, sitting directly upstream of the ALU. Captures one decoded instruction per cycle under a valid/ready handshake and holds it while downstream stalls. Presents ALU-ready operands with EX/MEM and MEM/WB forwarding and immediate selection applied. Normalises funct3/funct7 so that I-type, load and store instructions decode to the correct ALU operation.

## Interface
- XLEN, 64, datapath width
- CNT_W, 32, stall-cycle counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard held and incoming instruction (branch redirect)
- dec_valid / dec_ready  in / out  1  upstream handshake
- dec_funct3, dec_funct7  in  3, 7  raw instruction fields
- dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  5 each  register indices
- dec_rs1_data, dec_rs2_data  in  XLEN  register-file read data
- dec_imm  in  XLEN  sign-extended immediate
- dec_alu_src  in  1  1 = operand b is immediate
- dec_reg_write, dec_mem_read, dec_mem_write  in  1 each  control bits
- exmem_reg_write, exmem_mem_read  in  1  EX/MEM control
- exmem_rd_addr, memwb_rd_addr  in  5  forwarding destinations
- exmem_rd_data, memwb_rd_data  in  XLEN  forwarding data
- memwb_reg_write  in  1  MEM/WB control
- ex_valid / ex_ready  out / in  1  downstream handshake
- ex_funct3, ex_funct7  out  3, 7  normalised ALU function codes
- ex_rs1, ex_rs2  out  XLEN  ALU operands a, b
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd_addr  out  5;  ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- stall_cycles  out  CNT_W  count of load-use hazard cycles

## Operation
- One-entry register; valid_q marks occupancy. dec_ready = !valid_q || (ex_valid && ex_ready).
- Load on dec_valid && dec_ready && !flush; otherwise on output fire valid_q clears.
- flush: valid_q <= 0 next edge, overrides any load; incoming instruction dropped.
- Forwarding, per source (rs1, rs2), combinational on held addresses: EX/MEM match (reg_write, rd!=0, rd==src) wins over MEM/WB match; else held register data. x0 never forwarded.
- Load-use hazard: exmem_mem_read && exmem_reg_write && exmem_rd_addr!=0 && matches rs1, or rs2 when rs2 is used (!alu_src or mem_write). While hazard: ex_valid=0, entry held, stall_cycles +1 per cycle (wraps).
- ex_valid = valid_q && !hazard.
- ex_rs1 = fwd rs1; ex_rs2 = alu_src ? imm : fwd rs2; ex_store_data = fwd rs2.
- Normalisation: mem_read or mem_write -> funct3=000, funct7=0000000 (address add). alu_src non-memory: funct7=0100000 if funct3==101 && imm[10], else 0000000; funct3 passes. Register-register: pass both.
- Control outputs gated: ex_reg_write/mem_read/mem_write = held bit && ex_valid.

## Timing
- Reset: valid_q=0, all held payload 0, stall_cycles=0; thus ex_valid=0, every ex_* output 0, dec_ready=1.
- Latency: accepted instruction appears on ex_* the next cycle; forwarding adds no cycles.
- Full throughput with ex_ready=1: one instruction per cycle, back-to-back.
- ex_ready=0 with valid_q=1: dec_ready=0, outputs stable except forwarding data that tracks later stages.
- Simultaneous fire and load: new entry replaces old at same edge.
- flush during hazard: entry dropped, counter stops next cycle.
- rst_n low mid-stall: all state returns to reset values at that edge.

## Structure
- Shared package riscv_pkg: FUNCT7_BASE=7'b0000000, FUNCT7_ALT=7'b0100000, FUNCT3_ADD=3'b000, FUNCT3_SR=3'b101, REG_ZERO=5'd0.
- Sub-module forward_mux: one instance per source; inputs held addr/data plus both forwarding ports; outputs selected data and match flags.

## Test plan
- addi x1,x0,5 (imm=5, funct7 field garbage 0x7F) -> next cycle ex_valid=1, ex_rs1=0, ex_rs2=5, funct3=000, funct7=0000000.
- srai funct3=101, imm=0x403 -> ex_funct7=0100000, ex_rs2=0x403; imm=0x003 -> funct7=0000000.
- add rs1=x3 with exmem rd=x3 data=0xAA and memwb rd=x3 data=0xBB -> ex_rs1=0xAA; exmem rd=x0 -> held data used.
- Load in EX/MEM writing x4, held add uses x4 -> ex_valid=0, dec_ready=0, stall_cycles 0->1 per cycle; clearing exmem_mem_read -> ex_valid=1.
- ex_ready=0 for 3 cycles then 1 with dec_valid held -> no instruction lost or duplicated; order preserved.
- flush coinciding with dec_valid=1 -> ex_valid=0 next cycle; rst_n=0 mid-stall -> stall_cycles=0, all outputs 0.
